// File: rtl/ff256ct_pkg.sv
// ff256ct_pkg
//   Shared types and constants for the FF256 cosine-transform Wishbone master.
//   wbm_state_t : master FSM states, in bus-transaction order
//   ADR_LO/HI   : word addresses of the low/high 32-bit halves of a vector
//   SEL_ALL     : byte-select bit value, replicated to the byte-select width
package ff256ct_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        WR1,
        SETTLE,
        RD0,
        RD1,
        DONE
    } wbm_state_t;

    localparam logic ADR_LO  = 1'b0;
    localparam logic ADR_HI  = 1'b1;
    localparam logic SEL_ALL = '1;

    // States in which a strobe is presented to the peripheral.
    function automatic logic is_strobe_state(input wbm_state_t s);
        return (s == WR0) || (s == WR1) || (s == RD0) || (s == RD1);
    endfunction

    // States that hold the bus cycle open (strobes plus the settle gap).
    function automatic logic is_cycle_state(input wbm_state_t s);
        return is_strobe_state(s) || (s == SETTLE);
    endfunction

    function automatic logic is_write_state(input wbm_state_t s);
        return (s == WR0) || (s == WR1);
    endfunction

    function automatic logic is_high_word_state(input wbm_state_t s);
        return (s == WR1) || (s == RD1);
    endfunction

endpackage

// File: rtl/ff256ct_wb_timeout.sv
// ff256ct_wb_timeout
//   8-bit strobe watchdog. Counts cycles in which a strobe is waiting for ack.
//   clk     : clock
//   reset   : asynchronous, active-low reset
//   clr     : return count to zero (takes priority over en)
//   en      : strobe outstanding without ack this cycle
//   expired : this waiting cycle is the LIMIT-th one; the caller aborts on it
module ff256ct_wb_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of waiting cycles already elapsed, so the
    // current one is the LIMIT-th when count_q reaches LIMIT-1.
    assign expired = en && (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/ff256ct_wb_master.sv
// ff256ct_wb_master
//   Wishbone classic-cycle initiator for the FF256 cosine-transform peripheral.
//   Takes a 64-bit vector on in_*, writes it as two words (adr 0 = low,
//   adr 1 = high), waits for the peripheral result to settle, reads both
//   words back and offers the 64-bit result on out_*.
//   Streaming side : in_data/in_valid/in_ready, out_data/out_valid/out_ready,
//                    out_err (timeout abort), busy
//   Wishbone side  : adr_o, dat_o, dat_i, we_o, sel_o, stb_o, cyc_o, ack_i
//   All outputs are registered; reset is asynchronous, active-low.
module ff256ct_wb_master
    import ff256ct_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = 1,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BE_WIDTH      = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [63:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [63:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_err,
    output logic                  busy,
    output logic [BUS_WIDTH-1:0]  adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  we_o,
    output logic [BE_WIDTH-1:0]   sel_o,
    output logic                  stb_o,
    output logic                  cyc_o,
    input  logic                  ack_i
);

    wbm_state_t            state_q, state_d;
    logic [63:0]           vec_q, vec_d;
    logic [63:0]           out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_err_q, out_err_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic [BUS_WIDTH-1:0]  adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  we_q, we_d;
    logic [BE_WIDTH-1:0]   sel_q, sel_d;
    logic                  stb_q, stb_d;
    logic                  cyc_q, cyc_d;
    logic [7:0]            settle_q, settle_d;

    logic                  beat_ack;
    logic                  tmo_clr;
    logic                  tmo_en;
    logic                  tmo_expired;

    // ack_i only means something while our strobe is up.
    assign beat_ack = stb_q && ack_i;

    // Restart the watchdog whenever no strobe is out and at every completed
    // beat, so back-to-back beats (stb_o never falling) each get a full budget.
    assign tmo_clr  = !stb_q || ack_i;
    assign tmo_en   = stb_q && !ack_i;

    ff256ct_wb_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        settle_d    = settle_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    vec_d      = in_data;
                    out_data_d = '0;
                    state_d    = WR0;
                end
            end
            WR0: begin
                if (beat_ack) begin
                    state_d = WR1;
                end else if (tmo_expired) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                end
            end
            WR1: begin
                if (beat_ack) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end else if (tmo_expired) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d = RD0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            RD0: begin
                if (beat_ack) begin
                    out_data_d[DATA_WIDTH-1:0] = dat_i;
                    state_d                    = RD1;
                end else if (tmo_expired) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                end
            end
            RD1: begin
                if (beat_ack) begin
                    out_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = dat_i;
                    state_d                               = DONE;
                    out_valid_d                           = 1'b1;
                end else if (tmo_expired) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus and status outputs are decoded from the next state so the
        // registered copies line up with the state they belong to.
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        cyc_d      = is_cycle_state(state_d);
        stb_d      = is_strobe_state(state_d);
        we_d       = is_write_state(state_d);
        sel_d      = stb_d ? {BE_WIDTH{SEL_ALL}} : '0;
        adr_d      = is_high_word_state(state_d) ? BUS_WIDTH'(ADR_HI)
                                                 : BUS_WIDTH'(ADR_LO);
        case (state_d)
            WR0:     dat_d = vec_d[DATA_WIDTH-1:0];
            WR1:     dat_d = vec_d[2*DATA_WIDTH-1:DATA_WIDTH];
            default: dat_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            stb_q       <= stb_d;
            cyc_q       <= cyc_d;
            settle_q    <= settle_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign adr_o     = adr_q;
    assign dat_o     = dat_q;
    assign we_o      = we_q;
    assign sel_o     = sel_q;
    assign stb_o     = stb_q;
    assign cyc_o     = cyc_q;

endmodule
